// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and types shared by the instruction fetch unit.
//   INSTR_W      : default address/instruction width
//   DEF_RESET_PC : default first fetch address after reset
//   fetch_state_e: fetch FSM states (REQ = request phase, WAIT = response outstanding)
package fetch_unit_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetcher with redirect and a single-entry
// output buffer. At most one instruction-memory request is outstanding.
//   clk, rst                     : clock, synchronous active-high reset
//   redirect_i, redirect_pc_i    : taken branch/jump and its target
//   imem_req_o, imem_addr_o      : memory request valid / word-aligned address
//   imem_gnt_i                   : request accepted this cycle
//   imem_rvalid_i, imem_rdata_i  : one-cycle, unstallable response
//   instr_valid_o, instr_o,
//   instr_pc_o, instr_ready_i    : buffered instruction handshake to decode
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = INSTR_W,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             instr_valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] instr_pc_o,
    input  logic             instr_ready_i
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    fetch_state_e     state;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] pend_pc;     // address of the outstanding request
    logic             discard;     // outstanding response must be dropped
    logic             buf_valid;
    logic [WIDTH-1:0] buf_instr;
    logic [WIDTH-1:0] buf_pc;

    logic             consume;
    logic             grant;
    logic             load;
    logic [WIDTH-1:0] redirect_tgt;

    assign redirect_tgt  = redirect_pc_i & ALIGN_MASK;
    assign imem_addr_o   = fetch_pc & ALIGN_MASK;
    assign consume       = buf_valid & instr_ready_i;
    // Only request when the response is guaranteed a free buffer slot.
    assign imem_req_o    = (state == REQ) & (~buf_valid | instr_ready_i);
    assign grant         = imem_req_o & imem_gnt_i;
    assign load          = (state == WAIT) & imem_rvalid_i & ~discard & ~redirect_i;

    assign instr_valid_o = buf_valid;
    assign instr_o       = buf_instr;
    assign instr_pc_o    = buf_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REQ;
            fetch_pc  <= RESET_PC;
            pend_pc   <= '0;
            // A response still in flight from before reset must not be kept.
            discard   <= (state == WAIT);
            buf_valid <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (grant) begin
                        state    <= WAIT;
                        pend_pc  <= imem_addr_o;
                        fetch_pc <= redirect_i ? redirect_tgt : fetch_pc + WIDTH'(4);
                        discard  <= redirect_i;
                    end else begin
                        if (redirect_i)
                            fetch_pc <= redirect_tgt;
                        // Stale pre-reset response has now arrived and been ignored.
                        if (imem_rvalid_i)
                            discard <= 1'b0;
                    end
                end
                WAIT: begin
                    if (redirect_i)
                        fetch_pc <= redirect_tgt;
                    if (imem_rvalid_i) begin
                        state   <= REQ;
                        discard <= 1'b0;
                    end else if (redirect_i) begin
                        discard <= 1'b1;
                    end
                end
            endcase

            // Redirect wins; a consume in the same cycle is simply absorbed.
            if (redirect_i) begin
                buf_valid <= 1'b0;
            end else if (load) begin
                buf_valid <= 1'b1;
                buf_instr <= imem_rdata_i;
                buf_pc    <= pend_pc;
            end else if (consume) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked against a
// program-order model (delivered PCs must follow +4 from the last redirect).
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.WIDTH(32), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
    endfunction

    // Inputs change just after a falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic red, input logic [31:0] rpc);
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        instr_ready_i = rdy;
        redirect_i    = red;
        redirect_pc_i = rpc;
        #1;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        tick;
        tick;
        n_tests++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %h exp 0", instr_valid_o); end
        n_tests++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", instr_o); end
        n_tests++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", instr_pc_o); end
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        n_tests++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_req got %h exp 1", imem_req_o); end
        n_tests++; if (imem_addr_o !== RPC) begin n_fail++; $display("FAIL rst_addr got %h exp %h", imem_addr_o, RPC); end
        tick;
    endtask

    task automatic test_sequential;
        logic [31:0] a;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i) * 4;
            drive(1, 0, 32'h0, 1, 0, 32'h0);
            n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== a) begin n_fail++; $display("FAIL seq_req got %h/%h exp 1/%h", imem_req_o, imem_addr_o, a); end
            if (i > 0) begin
                n_tests++; if (instr_valid_o !== 1'b1 || instr_pc_o !== a - 4 || instr_o !== mem_word(a - 4)) begin n_fail++; $display("FAIL seq_instr got %h/%h/%h exp 1/%h/%h", instr_valid_o, instr_pc_o, instr_o, a - 4, mem_word(a - 4)); end
            end
            tick;
            drive(1, 1, mem_word(a), 1, 0, 32'h0);
            n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL seq_wait_req got %h exp 0", imem_req_o); end
            tick;
        end
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        n_tests++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h8 || instr_o !== mem_word(32'h8)) begin n_fail++; $display("FAIL seq_last got %h/%h/%h exp 1/8/%h", instr_valid_o, instr_pc_o, instr_o, mem_word(32'h8)); end
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin n_fail++; $display("FAIL seq_next got %h/%h exp 1/c", imem_req_o, imem_addr_o); end
        tick;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        n_tests++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL seq_drain got %h exp 0", instr_valid_o); end
        tick;
    endtask

    task automatic test_backpressure;
        do_reset;
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        tick;
        drive(1, 1, mem_word(32'h0), 0, 0, 32'h0);
        tick;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h0, 0, 0, 32'h0);
            n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req cyc %0d got %h exp 0", i, imem_req_o); end
            n_tests++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== mem_word(32'h0)) begin n_fail++; $display("FAIL bp_hold cyc %0d got %h/%h/%h exp 1/0/%h", i, instr_valid_o, instr_pc_o, instr_o, mem_word(32'h0)); end
            tick;
        end
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin n_fail++; $display("FAIL bp_release got %h/%h exp 1/4", imem_req_o, imem_addr_o); end
        tick;
        drive(0, 1, mem_word(32'h4), 1, 0, 32'h0);
        n_tests++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_consumed got %h exp 0", instr_valid_o); end
        tick;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        n_tests++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h4) begin n_fail++; $display("FAIL bp_second got %h/%h exp 1/4", instr_valid_o, instr_pc_o); end
        tick;
    endtask

    task automatic test_redirect_wait;
        do_reset;
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 32'h0, 1, 0, 32'h0);
            tick;
            drive(0, 1, mem_word(32'(i) * 4), 1, 0, 32'h0);
            tick;
        end
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        n_tests++; if (imem_addr_o !== 32'h8) begin n_fail++; $display("FAIL rw_addr8 got %h exp 8", imem_addr_o); end
        tick;
        drive(0, 0, 32'h0, 1, 1, 32'h103);
        tick;
        drive(0, 1, mem_word(32'h8), 1, 0, 32'h0);
        n_tests++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_wait got %h/%h exp 0/0", imem_req_o, instr_valid_o); end
        tick;
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        n_tests++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_dropped got %h exp 0", instr_valid_o); end
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL rw_target got %h/%h exp 1/100", imem_req_o, imem_addr_o); end
        tick;
        drive(0, 1, mem_word(32'h100), 1, 0, 32'h0);
        tick;
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        n_tests++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h100 || instr_o !== mem_word(32'h100)) begin n_fail++; $display("FAIL rw_deliver got %h/%h/%h exp 1/100/%h", instr_valid_o, instr_pc_o, instr_o, mem_word(32'h100)); end
        tick;
    endtask

    task automatic test_redirect_grant;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h0, 1, 0, 32'h0);
            tick;
            drive(0, 1, mem_word(32'(i) * 4), 1, 0, 32'h0);
            tick;
        end
        drive(1, 0, 32'h0, 1, 1, 32'h200);
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin n_fail++; $display("FAIL rg_addrc got %h/%h exp 1/c", imem_req_o, imem_addr_o); end
        tick;
        drive(0, 1, mem_word(32'hC), 1, 0, 32'h0);
        n_tests++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rg_wait got %h/%h exp 0/0", imem_req_o, instr_valid_o); end
        tick;
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        n_tests++; if (instr_valid_o !== 1'b0 || imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL rg_target got %h/%h exp 0/200", instr_valid_o, imem_addr_o); end
        tick;
        drive(0, 1, mem_word(32'h200), 1, 0, 32'h0);
        tick;
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        n_tests++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h200 || instr_o !== mem_word(32'h200)) begin n_fail++; $display("FAIL rg_deliver got %h/%h/%h exp 1/200/%h", instr_valid_o, instr_pc_o, instr_o, mem_word(32'h200)); end
        tick;
    endtask

    task automatic test_wrap;
        do_reset;
        drive(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFF);
        tick;
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        n_tests++; if (imem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top got %h exp fffffffc", imem_addr_o); end
        tick;
        drive(0, 1, mem_word(32'hFFFF_FFFC), 1, 0, 32'h0);
        tick;
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %h/%h exp 1/0", imem_req_o, imem_addr_o); end
        n_tests++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got %h/%h exp 1/fffffffc", instr_valid_o, instr_pc_o); end
        tick;
    endtask

    task automatic test_reset_wait;
        do_reset;
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        tick;
        rst = 1'b1;
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        tick;
        rst = 1'b0;
        drive(0, 1, 32'hBAD0_BAD0, 1, 0, 32'h0);
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== RPC) begin n_fail++; $display("FAIL rstw_req got %h/%h exp 1/%h", imem_req_o, imem_addr_o, RPC); end
        tick;
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        n_tests++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstw_stale got %h exp 0", instr_valid_o); end
        tick;
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        tick;
        drive(0, 1, mem_word(RPC), 1, 0, 32'h0);
        tick;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        n_tests++; if (instr_valid_o !== 1'b1 || instr_pc_o !== RPC || instr_o !== mem_word(RPC)) begin n_fail++; $display("FAIL rstw_fresh got %h/%h/%h exp 1/%h/%h", instr_valid_o, instr_pc_o, instr_o, RPC, mem_word(RPC)); end
        tick;
    endtask

    // Random memory latency, back-pressure and redirects. The model only tracks
    // the next PC the program should see: +4 per delivery, reset by redirects.
    task automatic test_random;
        logic [31:0] exp_pc, pend_addr, rpc;
        logic        pending, g, rv, rdy, red;
        int          delay, delivered;
        do_reset;
        exp_pc    = RPC;
        pending   = 1'b0;
        pend_addr = 32'h0;
        delay     = 0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            g   = ($urandom_range(0, 9) < 7);
            rv  = pending && (delay == 0);
            rdy = ($urandom_range(0, 3) != 0);
            red = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive(g, rv, mem_word(pend_addr), rdy, red, rpc);
            n_tests++; if (imem_req_o === 1'b1 && pending) begin n_fail++; $display("FAIL rnd_outstanding cyc %0d got req 1 exp 0", c); end
            n_tests++; if (imem_addr_o[1:0] !== 2'b00) begin n_fail++; $display("FAIL rnd_align cyc %0d got %h exp aligned", c, imem_addr_o); end
            if (instr_valid_o === 1'b1 && rdy) begin
                n_tests++; if (instr_pc_o !== exp_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %h exp %h", c, instr_pc_o, exp_pc); end
                n_tests++; if (instr_o !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_instr cyc %0d got %h exp %h", c, instr_o, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (red) exp_pc = rpc & ~32'h3;
            if (rv) pending = 1'b0;
            if (imem_req_o === 1'b1 && g) begin
                pending   = 1'b1;
                pend_addr = imem_addr_o;
                delay     = $urandom_range(0, 2);
            end else if (pending && delay > 0) begin
                delay--;
            end
            tick;
        end
        n_tests++; if (delivered < 100) begin n_fail++; $display("FAIL rnd_progress got %0d exp >=100", delivered); end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_backpressure;
        test_redirect_wait;
        test_redirect_grant;
        test_wrap;
        test_reset_wait;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
